// File: rtl/cpu_pkg.sv
// Shared definitions for the bit-scan sequencer: FSM state type and default
// scanned-word width.
package cpu_pkg;

    // Two-state sequencer: waiting for a word, or streaming its set-bit indices.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_e;

    // Default width of the word being enumerated.
    localparam int REGISTER_LENGTH_DEF = 64;

endpackage : cpu_pkg

// File: rtl/prio_enc_n.sv
// Combinational lowest-set-bit priority encoder.
// idx_o is the position of the least significant 1 in vec_i; none_o flags an
// all-zero vector, in which case idx_o is 0. REGISTER_LENGTH must be >= 2.
module prio_enc_n #(
    parameter  int REGISTER_LENGTH = cpu_pkg::REGISTER_LENGTH_DEF,
    localparam int IDX_W           = $clog2(REGISTER_LENGTH)
) (
    input  logic [REGISTER_LENGTH-1:0] vec_i,
    output logic [IDX_W-1:0]           idx_o,
    output logic                       none_o
);

    // Walk from the MSB down so the lowest set bit is the last one written.
    always_comb begin
        idx_o  = '0;
        none_o = ~|vec_i;
        for (int i = REGISTER_LENGTH - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule : prio_enc_n

// File: rtl/bit_scan_seq.sv
// Bit-scan sequencer: accepts a mask word and emits the index of every set
// bit, lowest first, one beat per handshake. An all-zero word yields a single
// beat flagged empty.
// Optional feature: define BIT_SCAN_SEQ_COUNT_EN to add out_cnt_o, the
// 0-based ordinal of the current beat within its word.
module bit_scan_seq
    import cpu_pkg::*;
#(
    parameter  int REGISTER_LENGTH = REGISTER_LENGTH_DEF,
    localparam int IDX_W           = $clog2(REGISTER_LENGTH)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       in_valid_i,
    input  logic [REGISTER_LENGTH-1:0] word_i,
    output logic                       in_ready_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [IDX_W-1:0]           out_idx_o,
    output logic                       out_last_o,
    output logic                       out_empty_o
`ifdef BIT_SCAN_SEQ_COUNT_EN
    ,
    output logic [IDX_W:0]             out_cnt_o
`endif
);

    scan_state_e                state_q, state_d;
    logic [REGISTER_LENGTH-1:0] residual_q, residual_d;

    logic [REGISTER_LENGTH-1:0] residual_cleared;
    logic                       is_last;
    logic [IDX_W-1:0]           enc_idx;
    logic                       enc_none;
    logic                       beat_fire;

    prio_enc_n #(
        .REGISTER_LENGTH(REGISTER_LENGTH)
    ) u_prio_enc (
        .vec_i (residual_q),
        .idx_o (enc_idx),
        .none_o(enc_none)
    );

    // x & (x-1) drops the lowest set bit; zero result means at most one bit
    // remains, which also covers the empty-word beat.
    assign residual_cleared = residual_q & (residual_q - REGISTER_LENGTH'(1));
    assign is_last          = (residual_cleared == '0);
    assign beat_fire        = (state_q == SCAN) && out_ready_i;

    // State and residual registers; reset aborts any word in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            residual_q <= '0;
        end else begin
            state_q    <= state_d;
            residual_q <= residual_d;
        end
    end

    // Next-state and output decode; outputs are driven only from registers so
    // they hold steady while the consumer stalls.
    always_comb begin
        state_d     = state_q;
        residual_d  = residual_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        out_idx_o   = '0;
        out_last_o  = 1'b0;
        out_empty_o = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    residual_d = word_i;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                out_valid_o = 1'b1;
                out_idx_o   = enc_idx;
                out_last_o  = is_last;
                out_empty_o = enc_none;
                if (out_ready_i) begin
                    residual_d = residual_cleared;
                    if (is_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef BIT_SCAN_SEQ_COUNT_EN
    logic [IDX_W:0] cnt_q, cnt_d;

    // Beat ordinal: advance on each accepted beat, restart after the last.
    always_comb begin
        cnt_d = cnt_q;
        if (beat_fire) begin
            cnt_d = is_last ? '0 : cnt_q + (IDX_W + 1)'(1);
        end
    end

    // Ordinal register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_cnt_o = cnt_q;
`else
    logic unused_fire;
    assign unused_fire = beat_fire;
`endif

endmodule : bit_scan_seq

// File: tb/tb_bit_scan_seq.sv
// Directed self-checking bench for bit_scan_seq (REGISTER_LENGTH = 64).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_bit_scan_seq;

    localparam int W     = 64;
    localparam int IDX_W = 6;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [W-1:0]     word;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             out_empty;
`ifdef BIT_SCAN_SEQ_COUNT_EN
    logic [IDX_W:0]   out_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    bit_scan_seq #(.REGISTER_LENGTH(W)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .in_valid_i (in_valid),
        .word_i     (word),
        .in_ready_o (in_ready),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_idx_o  (out_idx),
        .out_last_o (out_last),
        .out_empty_o(out_empty)
`ifdef BIT_SCAN_SEQ_COUNT_EN
        ,
        .out_cnt_o  (out_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Check one presented beat at the current sample point.
    task automatic expect_beat(input string tag, input int idx, input bit last, input bit empty);
        check_eq({tag, " valid"}, 64'(out_valid), 64'd1);
        check_eq({tag, " idx"}, 64'(out_idx), 64'(idx));
        check_eq({tag, " last"}, 64'(out_last), 64'(last));
        check_eq({tag, " empty"}, 64'(out_empty), 64'(empty));
        check_eq({tag, " in_ready"}, 64'(in_ready), 64'd0);
        $display("beat %s: idx=%0d last=%0b empty=%0b", tag, out_idx, out_last, out_empty);
    endtask

    // Present a word for exactly one cycle (DUT must be idle).
    task automatic send_word(input string tag, input logic [W-1:0] w);
        check_eq({tag, " accept ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        word     = w;
        tick();
        in_valid = 1'b0;
        $display("word %s: %h", tag, w);
    endtask

    initial begin
        int exp_i;
        bit ready_pat [12];
        bit stall_pat [12] = '{1, 0, 0, 1, 0, 1, 0, 0, 1, 1, 1, 1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        word      = '0;
        out_ready = 1'b0;

        // Reset state
        tick();
        check_eq("rst valid", 64'(out_valid), 64'd0);
        check_eq("rst idx", 64'(out_idx), 64'd0);
        check_eq("rst last", 64'(out_last), 64'd0);
        check_eq("rst empty", 64'(out_empty), 64'd0);
        rst_n = 1'b1;
        tick();
        check_eq("post-rst in_ready", 64'(in_ready), 64'd1);

        // Sparse word with MSB set, consumer always ready
        out_ready = 1'b1;
        send_word("sparse", 64'h8000_0000_0000_0005);
        expect_beat("sparse0", 0, 1'b0, 1'b0);
        tick();
        expect_beat("sparse1", 2, 1'b0, 1'b0);
        tick();
        expect_beat("sparse2", 63, 1'b1, 1'b0);
        tick();
        check_eq("sparse done valid", 64'(out_valid), 64'd0);
        check_eq("sparse done ready", 64'(in_ready), 64'd1);

        // All-zero word
        send_word("zero", 64'h0);
        expect_beat("zero0", 0, 1'b1, 1'b1);
        tick();
        check_eq("zero done valid", 64'(out_valid), 64'd0);
        check_eq("zero done ready", 64'(in_ready), 64'd1);

        // Stalling consumer: each beat must hold until taken
        ready_pat = stall_pat;
        out_ready = ready_pat[0];
        send_word("stall", 64'hF);
        exp_i = 0;
        for (int c = 0; c < 12 && exp_i < 4; c++) begin
            out_ready = ready_pat[c];
            expect_beat($sformatf("stall c%0d", c), exp_i, exp_i == 3, 1'b0);
            if (out_ready && out_valid) exp_i++;
            tick();
        end
        check_eq("stall beats taken", 64'(exp_i), 64'd4);
        check_eq("stall done valid", 64'(out_valid), 64'd0);
        check_eq("stall done ready", 64'(in_ready), 64'd1);

        // Reset in the middle of an all-ones word
        out_ready = 1'b1;
        send_word("ones", '1);
        for (int i = 0; i < 10; i++) begin
            expect_beat($sformatf("ones%0d", i), i, 1'b0, 1'b0);
            tick();
        end
        expect_beat("ones10", 10, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async rst valid", 64'(out_valid), 64'd0);
        check_eq("async rst idx", 64'(out_idx), 64'd0);
        check_eq("async rst last", 64'(out_last), 64'd0);
        check_eq("async rst empty", 64'(out_empty), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("after abort valid", 64'(out_valid), 64'd0);
        check_eq("after abort ready", 64'(in_ready), 64'd1);
        send_word("post-abort", 64'h3);
        expect_beat("post0", 0, 1'b0, 1'b0);
        tick();
        expect_beat("post1", 1, 1'b1, 1'b0);
        tick();
        check_eq("post done valid", 64'(out_valid), 64'd0);

        // Second word held on input during a scan is ignored until idle
        check_eq("hold accept ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        word     = 64'h6;
        tick();
        word     = 64'h1_0000;
        expect_beat("holdA0", 1, 1'b0, 1'b0);
        tick();
        expect_beat("holdA1", 2, 1'b1, 1'b0);
        tick();
        check_eq("hold idle valid", 64'(out_valid), 64'd0);
        check_eq("hold idle ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        expect_beat("holdB0", 16, 1'b1, 1'b0);
        tick();
        check_eq("holdB done valid", 64'(out_valid), 64'd0);

        // Two-bit word; ordinal checked when the count output is built in
        send_word("cnt", 64'h0000_0000_0000_0110);
        expect_beat("cnt0", 4, 1'b0, 1'b0);
`ifdef BIT_SCAN_SEQ_COUNT_EN
        check_eq("cnt0 ordinal", 64'(out_cnt), 64'd0);
`endif
        tick();
        expect_beat("cnt1", 8, 1'b1, 1'b0);
`ifdef BIT_SCAN_SEQ_COUNT_EN
        check_eq("cnt1 ordinal", 64'(out_cnt), 64'd1);
`endif
        tick();
        check_eq("cnt done valid", 64'(out_valid), 64'd0);
`ifdef BIT_SCAN_SEQ_COUNT_EN
        check_eq("cnt cleared", 64'(out_cnt), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_bit_scan_seq
